// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer
//   Steps the 3-bit select of an 8:1 channel mux through every channel. After
//   each select change it waits a programmable settle time, then samples the
//   mux output once. The sampled bits are reassembled into a parallel word,
//   which is presented with a one-cycle valid strobe. Both single-shot and
//   continuous scans are supported.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   scan request, honoured only while idle
//   cont       in   continuous mode, sampled on the last channel's sample cycle
//   abort      in   synchronous abort; drops the scan in progress
//   mux_y      in   output of the 8:1 mux
//   sel        out  mux select, drives s[2:0] directly
//   busy       out  high whenever a scan is in progress
//   word       out  last completed scan; bit i = mux_y sampled while sel==i
//   word_valid out  one-cycle strobe, asserted on the edge that updates word
module mux_scan_sequencer #(
  parameter int unsigned N_CH   = 8,
  parameter int unsigned SEL_W  = 3,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             abort,
  input  logic             mux_y,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic [N_CH-1:0]  word,
  output logic             word_valid
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_t;

  state_t           state, state_d;
  logic [SEL_W-1:0] sel_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [N_CH-1:0]  shadow, shadow_d;
  logic [N_CH-1:0]  word_d;
  logic             word_valid_d;
  logic             busy_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sel        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_d;
      sel        <= sel_d;
      cnt        <= cnt_d;
      shadow     <= shadow_d;
      word       <= word_d;
      word_valid <= word_valid_d;
      busy       <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d      = state;
    sel_d        = sel;
    cnt_d        = '0;
    shadow_d     = shadow;
    word_d       = word;
    word_valid_d = 1'b0;

    case (state)
      ST_IDLE: begin
        sel_d = '0;
        if (start && !abort) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      ST_SAMPLE: begin
        shadow_d[sel] = mux_y;
        state_d       = ST_SETTLE;
        if (sel != SEL_LAST) begin
          sel_d = sel + 1'b1;
        end else begin
          // The last bit comes straight from mux_y; the shadow register
          // has not captured it yet on this edge.
          word_d       = {mux_y, shadow[N_CH-2:0]};
          word_valid_d = 1'b1;
          sel_d        = '0;
          if (!cont) begin
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        sel_d   = '0;
      end
    endcase

    // Abort wins over everything, including completion of the last channel.
    if (abort && (state != ST_IDLE)) begin
      state_d      = ST_IDLE;
      sel_d        = '0;
      cnt_d        = '0;
      shadow_d     = '0;
      word_d       = word;
      word_valid_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer
//   Two instances: dut_a (settle 1, ideal mux) and dut_b (settle 3, mux
//   output lagging the select by two cycles). Expected words are queued with
//   the cycle they must appear on; per-instance monitors pop and compare on
//   every word_valid strobe.
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] word;
    int         cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  // dut_a: settle 1, ideal mux
  logic       start_a, cont_a, abort_a, mux_y_a, busy_a, wv_a;
  logic [2:0] sel_a;
  logic [7:0] word_a, a_a;
  assign mux_y_a = a_a[sel_a];

  // dut_b: settle 3, mux output follows sel two cycles late
  logic       start_b, cont_b, abort_b, mux_y_b, busy_b, wv_b;
  logic [2:0] sel_b, d1_b, d2_b;
  logic [7:0] word_b, a_b;
  always @(posedge clk) begin
    d1_b <= sel_b;
    d2_b <= d1_b;
  end
  assign mux_y_b = a_b[d2_b];

  mux_scan_sequencer #(.N_CH(8), .SEL_W(3), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .abort(abort_a),
    .mux_y(mux_y_a), .sel(sel_a), .busy(busy_a), .word(word_a), .word_valid(wv_a)
  );

  mux_scan_sequencer #(.N_CH(8), .SEL_W(3), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .abort(abort_b),
    .mux_y(mux_y_b), .sel(sel_b), .busy(busy_b), .word(word_b), .word_valid(wv_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic goto(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Scoreboard monitor for dut_a
  logic prev_wv_a = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wv_a) begin
        chk("a_no_back_to_back", 32'(prev_wv_a), 32'd0);
        if (q_a.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL a_unexpected_strobe: got word %0h at cycle %0d expected no strobe", word_a, cyc);
        end else begin
          e_a = q_a.pop_front();
          chk("a_word", 32'(word_a), 32'(e_a.word));
          chk("a_strobe_cycle", 32'(cyc), 32'(e_a.cyc));
        end
      end
      prev_wv_a = wv_a;
    end else begin
      prev_wv_a = 1'b0;
    end
  end

  // Scoreboard monitor for dut_b
  logic prev_wv_b = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (wv_b) begin
        chk("b_no_back_to_back", 32'(prev_wv_b), 32'd0);
        if (q_b.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL b_unexpected_strobe: got word %0h at cycle %0d expected no strobe", word_b, cyc);
        end else begin
          e_b = q_b.pop_front();
          chk("b_word", 32'(word_b), 32'(e_b.word));
          chk("b_strobe_cycle", 32'(cyc), 32'(e_b.cyc));
        end
      end
      prev_wv_b = wv_b;
    end else begin
      prev_wv_b = 1'b0;
    end
  end

  // Time limit
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    start_a = 1'b0; cont_a = 1'b0; abort_a = 1'b0; a_a = 8'h00;
    start_b = 1'b0; cont_b = 1'b0; abort_b = 1'b0; a_b = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sel", 32'(sel_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_word", 32'(word_a), 32'd0);
    chk("rst_valid", 32'(wv_a), 32'd0);
    chk("rst_word_b", 32'(word_b), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-shot scan, a=A5: sel steps 0..7, two cycles each
    a_a = 8'hA5;
    start_a = 1'b1;
    base = cyc + 1;
    q_a.push_back('{8'hA5, base + 16});
    @(negedge clk);
    start_a = 1'b0;
    for (int n = 0; n <= 16; n++) begin
      goto(base + n);
      chk("t1_sel", 32'(sel_a), (n == 16) ? 32'd0 : 32'(n / 2));
      chk("t1_busy", 32'(busy_a), (n < 16) ? 32'd1 : 32'd0);
    end

    // Continuous scan: 3C then C3, wrap without idle
    @(negedge clk);
    a_a = 8'h3C;
    cont_a = 1'b1;
    start_a = 1'b1;
    base = cyc + 1;
    q_a.push_back('{8'h3C, base + 16});
    q_a.push_back('{8'hC3, base + 32});
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 16);
    chk("t2_busy_wrap", 32'(busy_a), 32'd1);
    chk("t2_sel_wrap", 32'(sel_a), 32'd0);
    a_a = 8'hC3;
    cont_a = 1'b0;
    goto(base + 17);
    chk("t2_sel_hold", 32'(sel_a), 32'd0);
    goto(base + 18);
    chk("t2_sel_step", 32'(sel_a), 32'd1);
    goto(base + 33);
    chk("t2_idle", 32'(busy_a), 32'd0);

    // Settle 3 with lagging mux, a=81
    a_b = 8'h81;
    start_b = 1'b1;
    base = cyc + 1;
    q_b.push_back('{8'h81, base + 32});
    @(negedge clk);
    start_b = 1'b0;
    goto(base + 40);
    chk("t3_word_hold", 32'(word_b), 32'h81);
    chk("t3_idle", 32'(busy_b), 32'd0);

    // Reset in the middle of a scan
    a_a = 8'hFF;
    start_a = 1'b1;
    base = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 9);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_sel", 32'(sel_a), 32'd0);
    chk("t4_busy", 32'(busy_a), 32'd0);
    chk("t4_word", 32'(word_a), 32'd0);
    chk("t4_valid", 32'(wv_a), 32'd0);
    chk("t4_word_b", 32'(word_b), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    goto(cyc + 20);
    chk("t4_word_after", 32'(word_a), 32'd0);
    chk("t4_busy_after", 32'(busy_a), 32'd0);

    // Stray start pulses while busy are ignored
    a_a = 8'h55;
    start_a = 1'b1;
    base = cyc + 1;
    q_a.push_back('{8'h55, base + 16});
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 3);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 10);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 17);
    chk("t5_no_restart", 32'(busy_a), 32'd0);

    // Establish word=A5
    a_a = 8'hA5;
    start_a = 1'b1;
    base = cyc + 1;
    q_a.push_back('{8'hA5, base + 16});
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 17);

    // Abort mid-scan with a=55
    a_a = 8'h55;
    start_a = 1'b1;
    base = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 7);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("t6_abort_busy", 32'(busy_a), 32'd0);
    chk("t6_abort_sel", 32'(sel_a), 32'd0);
    goto(base + 25);
    chk("t6_word_kept", 32'(word_a), 32'hA5);

    // Abort on the last channel's sample cycle beats completion
    start_a = 1'b1;
    base = cyc + 1;
    @(negedge clk);
    start_a = 1'b0;
    goto(base + 15);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("t7_abort_last_busy", 32'(busy_a), 32'd0);
    chk("t7_abort_last_word", 32'(word_a), 32'hA5);
    @(negedge clk);
    chk("t7_abort_last_valid", 32'(wv_a), 32'd0);

    // start and abort together while idle: stay idle
    start_a = 1'b1;
    abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("t8_idle_1", 32'(busy_a), 32'd0);
    @(negedge clk);
    chk("t8_idle_2", 32'(busy_a), 32'd0);

    repeat (20) @(negedge clk);
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
